m68k_bus_master: RTL

//  CPLD-side initiator for 68000-style asynchronous bus cycles on the shared board bus.
//  It is used in boot mode, when the CPU is held off the bus, to program and verify the EEPROM and RAM.

---
 rtl/m68k_bus_master_pkg.sv | 5 +
 rtl/m68k_bus_master_sync2.sv | 14 +
 rtl/m68k_bus_master.sv | 115 +++++++++++
 3 files changed

// File: rtl/m68k_bus_master_pkg.sv
// m68k_bus_master_pkg: state encoding and bus constants shared by the bus master
package m68k_bus_master_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ASSERT, S_WAIT, S_RELEASE, S_RECOVER} state_t;
  localparam logic [1:0] BE_NONE = 2'b00;
endpackage

// File: rtl/m68k_bus_master_sync2.sv
// m68k_bus_master_sync2: 2-flop synchroniser for active-low bus inputs, resets to 1
module m68k_bus_master_sync2 #(
  parameter int W = 2
) (
  input  logic         clk16,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk16 or posedge rst)
    if (rst) {q, m} <= '1;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: single-word 68000-style async bus cycle initiator for boot-mode programming
module m68k_bus_master
  import m68k_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk16,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_tmo,
  output logic [22:0] a_out,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        rw,
  input  logic        dtack_n,
  input  logic        berr_n
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             r_rw;
  logic [1:0]       r_be;
  logic             dtack_s, berr_s;
  logic             tmo_hit;
  m68k_bus_master_sync2 #(.W(2)) u_sync (
    .clk16(clk16),
    .rst  (rst),
    .d    ({berr_n, dtack_n}),
    .q    ({berr_s, dtack_s})
  );
  assign req_ready = state == S_IDLE;
  assign tmo_hit   = cnt == CNT_MAX;
  always_ff @(posedge clk16 or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      r_rw      <= 1'b1;
      r_be      <= '0;
      as_n      <= 1'b1;
      uds_n     <= 1'b1;
      lds_n     <= 1'b1;
      rw        <= 1'b1;
      d_oe      <= 1'b0;
      a_out     <= '0;
      d_out     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      // saturating counter shared by WAIT timeout and RECOVER bound
      cnt <= state inside {S_WAIT, S_RECOVER} ? cnt + CNT_W'(!tmo_hit) : '0;
      case (state)
        S_IDLE:
          if (req_valid) begin
            if (req_be == BE_NONE) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= S_ADDR;
              r_rw  <= req_rw;
              r_be  <= req_be;
              a_out <= req_addr;
              rw    <= req_rw;
              d_out <= req_wdata;
              d_oe  <= !req_rw;
            end
          end
        S_ADDR: begin
          state          <= S_ASSERT;
          as_n           <= 1'b0;
          {uds_n, lds_n} <= r_rw ? ~r_be : 2'b11;
        end
        S_ASSERT: begin
          state          <= S_WAIT;
          {uds_n, lds_n} <= ~r_be;
        end
        S_WAIT:
          if (!berr_s || !dtack_s || tmo_hit) begin
            state     <= S_RELEASE;
            as_n      <= 1'b1;
            uds_n     <= 1'b1;
            lds_n     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= !berr_s || dtack_s;
            rsp_tmo   <= berr_s && dtack_s;
            if (berr_s && !dtack_s && r_rw) rsp_rdata <= d_in;
          end
        S_RELEASE: begin
          state <= S_RECOVER;
          d_oe  <= 1'b0;
          rw    <= 1'b1;
        end
        S_RECOVER:
          if ((dtack_s && berr_s) || tmo_hit) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule
